servo_move_sequencer: RTL and testbench
=======================================

// Module: servo_move_sequencer
// PURPOSE
// APB3 slave that queues timed pan/tilt servo moves and plays them out on a shared 20 ms PWM timebase.
// Each command is {axis, direction, period count}. It drives one axis at full forward, full reverse or neutral
// for N PWM periods, and keeps signed per-axis position counts. It replaces direct CPU pulse-width pokes.
// PARAMETERS
// FIFO_DEPTH      8        command FIFO entries (power of 2)
// FIFO_AW         3        log2(FIFO_DEPTH)
// PWM_PERIOD      2000000  PWM period in PCLK cycles (20 ms @ 100 MHz)
// PW_NEUTRAL      150000   neutral pulse width, cycles
// PW_FULL_REVERSE 100000   full-reverse pulse width, cycles
// PW_FULL_FORWARD 200000   full-forward pulse width, cycles
// PORTS
// PCLK         in   1   clock, 100 MHz
// PRESERN      in   1   reset, asynchronous, active-low
// PSEL         in   1   APB select
// PENABLE      in   1   APB access phase
// PWRITE       in   1   1 = write
// PADDR        in   32  address; bits [11:0] decoded
// PWDATA       in   32  write data
// PRDATA       out  32  read data, combinational, valid in access phase
// PREADY       out  1   tied 1 (no wait states)
// PSLVERR      out  1   tied 0
// x_servo_pwm  out  1   X servo PWM
// y_servo_pwm  out  1   Y servo PWM
// seq_done_irq out  1   present only with SERVO_SEQ_IRQ_EN
// BEHAVIOUR
// Writes take effect when PSEL&PENABLE&PWRITE. Register map:
//  0x200 W CMD: [18] axis (0=X, 1=Y), [17:16] dir (01 fwd, 10 rev, 00/11 neutral hold), [15:0] periods; pushes one entry.
//  0x204 W CTRL: [0] run, [1] flush (self-clearing), [2] clear err, [3] clear irq.
//  0x208 R STATUS: [0] err, [1] busy, [2] empty, [3] full, [7:4] fill, [8] irq, [31:9] 0.
//  0x20C R XPOS, signed 32. 0x210 R YPOS, signed 32. Other addresses read 0; writes to them are ignored.
// Reset: FIFO empty; run=0; err=0; irq=0; XPOS=YPOS=0; period counter=0; both pw=PW_NEUTRAL; PWM outputs 0.
//  First cycle after reset release: PWM outputs go high.
// PWM: counter runs 0..PWM_PERIOD-1. Output is high while counter < pw, and is registered (1 cycle lag).
//  A boundary occurs on the cycle where counter==PWM_PERIOD-1.
//  pw registers change only at a boundary, so no clipped or stretched pulse is possible.
// Sequencer FSM IDLE/RUN, evaluated only at boundaries:
//  Position: an axis commanded fwd for the just-completed period gets +1; rev gets -1. Two's-complement wrap.
//  RUN with remaining>1: remaining-1; pw held.
//  RUN with remaining==1, or IDLE: if run=1 and FIFO not empty, pop, latch the new command, state=RUN.
//   The commanded axis gets its pw from dir. The other axis gets PW_NEUTRAL. remaining = periods.
//  Otherwise: both pw=PW_NEUTRAL, state=IDLE. A RUN->IDLE transition through this path sets irq.
// busy=1 while in RUN.
// CMD with periods==0 is rejected: not pushed, err set.
// Push when full is dropped and sets err. err is sticky until a CTRL[2] write.
// Push and pop in the same cycle: both happen, fill unchanged.
// Flush: empties the FIFO immediately. The active command is aborted at the next boundary.
//  That boundary still counts the completed period into position; positions are retained.
//  Flush and push in the same cycle: flush wins, push dropped (no err).
// run cleared mid-command: the active command completes, then no further pops.
// Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
// SERVO_SEQ_IRQ_EN defined: seq_done_irq port exists and equals the sticky irq bit. CTRL[3] clears irq.
//  If the set and the clear fall in the same cycle, the set wins.
// SERVO_SEQ_IRQ_EN undefined: no seq_done_irq port, no irq flop. STATUS[8] reads 0; CTRL[3] is ignored.
// TESTING
// T1 Reset release, no commands: X/Y high 150000 cycles of every 2000000; STATUS=0x004; XPOS=YPOS=0.
// T2 Push X fwd 3, set run: next 3 periods X high 200000, then X returns to 150000.
//    Y stays 150000 throughout; XPOS=3; busy falls at 4th boundary.
// T3 Push 8 cmds with run=0 -> STATUS full=1, fill=8. 9th push dropped, err=1.
//    CTRL[2] clears err. CMD with periods=0 -> err=1, fill unchanged.
// T4 Push cmd at counter=1000000 mid-period with run=1: no pulse differs from 150000 or 200000.
//    The new width starts in the period after the next boundary.
// T5 Y rev 10 running; flush written during the 5th period.
//    Period 6 Y is neutral; YPOS=-5; FIFO empty; with IRQ_EN, seq_done_irq=1.
// T6 Assert PRESERN low mid-command, then release: PWM outputs 0 during reset.
//    After release: FIFO empty, XPOS=YPOS=0, neutral pulses resume from counter 0.

Source files
------------

// File: rtl/servo_move_sequencer.sv
// servo_move_sequencer
// APB3 slave that queues timed pan/tilt servo moves and plays them out on a
// shared PWM timebase. Each queued command drives one axis at full forward,
// full reverse or neutral for a number of PWM periods, and signed per-axis
// position counts track the completed forward/reverse periods.
//
// Ports:
//   PCLK, PRESERN          clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE    APB3 control
//   PADDR, PWDATA          APB3 address (bits [11:0] decoded) and write data
//   PRDATA                 combinational read data
//   PREADY, PSLVERR        tied 1 / tied 0
//   x_servo_pwm            X servo PWM output (registered)
//   y_servo_pwm            Y servo PWM output (registered)
//   seq_done_irq           sticky sequence-done interrupt (SERVO_SEQ_IRQ_EN only)
//
// Build option: define SERVO_SEQ_IRQ_EN to add the irq flop and seq_done_irq port.
module servo_move_sequencer #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned FIFO_AW         = 3,
  parameter int unsigned PWM_PERIOD      = 2000000,
  parameter int unsigned PW_NEUTRAL      = 150000,
  parameter int unsigned PW_FULL_REVERSE = 100000,
  parameter int unsigned PW_FULL_FORWARD = 200000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        x_servo_pwm,
`ifdef SERVO_SEQ_IRQ_EN
  output logic        y_servo_pwm,
  output logic        seq_done_irq
`else
  output logic        y_servo_pwm
`endif
);

  localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0] CntMax = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] PwNeu  = CW'(PW_NEUTRAL);
  localparam logic [CW-1:0] PwRev  = CW'(PW_FULL_REVERSE);
  localparam logic [CW-1:0] PwFwd  = CW'(PW_FULL_FORWARD);
  localparam logic [FIFO_AW:0] FifoFull = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  // APB decode
  logic [11:0] addr;
  logic        wr_en, cmd_wr, ctrl_wr, flush, cmd_ok, push, pop, err_set, boundary, abort;
  assign addr    = PADDR[11:0];
  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign cmd_wr  = wr_en && (addr == 12'h200);
  assign ctrl_wr = wr_en && (addr == 12'h204);
  assign flush   = ctrl_wr & PWDATA[1];
  assign cmd_ok  = (PWDATA[15:0] != 16'd0);

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:12], PWDATA[31:19], PWDATA[3]};

  // State
  logic [CW-1:0]      cnt_q, x_pw_q, x_pw_d, y_pw_q, y_pw_d;
  logic               x_pwm_q, y_pwm_q;
  logic               state_q, state_d, axis_q, axis_d;
  logic [1:0]         dir_q, dir_d;
  logic [15:0]        rem_q, rem_d;
  logic [31:0]        xpos_q, xpos_d, ypos_q, ypos_d;
  logic               run_q, err_q, flush_pend_q, irq_set;
  logic [18:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               fifo_empty, fifo_full;
  logic [18:0]        head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FifoFull);
  assign head       = mem_q[rd_ptr_q];
  assign boundary   = (cnt_q == CntMax);

  // A flush (now or earlier in this period) ends the active command at the boundary.
  assign abort   = flush_pend_q | flush;
  // Flush wins over a same-cycle push and suppresses its error.
  assign push    = cmd_wr & cmd_ok & ~fifo_full & ~flush;
  assign err_set = cmd_wr & ~flush & (~cmd_ok | fifo_full);
  assign pop     = boundary & run_q & ~fifo_empty & ~flush &
                   ((state_q == StIdle) || (rem_q == 16'd1) || abort);

  function automatic logic [CW-1:0] pw_of(input logic [1:0] dir);
    unique case (dir)
      2'b01:   pw_of = PwFwd;
      2'b10:   pw_of = PwRev;
      default: pw_of = PwNeu;
    endcase
  endfunction

  // Sequencer next state; only evaluated at period boundaries.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    axis_d  = axis_q;
    dir_d   = dir_q;
    x_pw_d  = x_pw_q;
    y_pw_d  = y_pw_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    irq_set = 1'b0;
    if (boundary) begin
      if (state_q == StRun) begin
        if (dir_q == 2'b01) begin
          if (axis_q) ypos_d = ypos_q + 32'd1;
          else        xpos_d = xpos_q + 32'd1;
        end else if (dir_q == 2'b10) begin
          if (axis_q) ypos_d = ypos_q - 32'd1;
          else        xpos_d = xpos_q - 32'd1;
        end
      end
      if ((state_q == StRun) && (rem_q > 16'd1) && !abort) begin
        rem_d = rem_q - 16'd1;
      end else if (pop) begin
        state_d = StRun;
        axis_d  = head[18];
        dir_d   = head[17:16];
        rem_d   = head[15:0];
        x_pw_d  = head[18] ? PwNeu : pw_of(head[17:16]);
        y_pw_d  = head[18] ? pw_of(head[17:16]) : PwNeu;
      end else begin
        state_d = StIdle;
        x_pw_d  = PwNeu;
        y_pw_d  = PwNeu;
        irq_set = (state_q == StRun);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt_q        <= '0;
      x_pw_q       <= PwNeu;
      y_pw_q       <= PwNeu;
      x_pwm_q      <= 1'b0;
      y_pwm_q      <= 1'b0;
      state_q      <= StIdle;
      axis_q       <= 1'b0;
      dir_q        <= 2'b00;
      rem_q        <= '0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      run_q        <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      cnt_q        <= boundary ? '0 : cnt_q + 1'b1;
      x_pwm_q      <= (cnt_q < x_pw_q);
      y_pwm_q      <= (cnt_q < y_pw_q);
      x_pw_q       <= x_pw_d;
      y_pw_q       <= y_pw_d;
      state_q      <= state_d;
      axis_q       <= axis_d;
      dir_q        <= dir_d;
      rem_q        <= rem_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      if (ctrl_wr) run_q <= PWDATA[0];
      if (err_set) err_q <= 1'b1;
      else if (ctrl_wr && PWDATA[2]) err_q <= 1'b0;
      flush_pend_q <= boundary ? 1'b0 : (flush | flush_pend_q);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= PWDATA[18:0];
  end

  logic irq_bit;
`ifdef SERVO_SEQ_IRQ_EN
  logic irq_q;
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN)                       irq_q <= 1'b0;
    else if (irq_set)                   irq_q <= 1'b1;  // set beats same-cycle clear
    else if (ctrl_wr && PWDATA[3])      irq_q <= 1'b0;
  end
  assign irq_bit      = irq_q;
  assign seq_done_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_set;
  assign irq_bit    = 1'b0;
`endif

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      unique case (addr)
        12'h208: PRDATA = {23'd0, irq_bit, 4'(count_q), fifo_full, fifo_empty,
                           (state_q == StRun), err_q};
        12'h20C: PRDATA = xpos_q;
        12'h210: PRDATA = ypos_q;
        default: PRDATA = 32'd0;
      endcase
    end
  end

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign x_servo_pwm = x_pwm_q;
  assign y_servo_pwm = y_pwm_q;

endmodule

// File: tb/tb_servo_move_sequencer.sv
module tb_servo_move_sequencer;
  localparam int P   = 200;
  localparam int NEU = 15;
  localparam int REV = 10;
  localparam int FWD = 20;
`ifdef SERVO_SEQ_IRQ_EN
  localparam logic [31:0] IRQB = 32'h100;
`else
  localparam logic [31:0] IRQB = 32'h000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, xpwm, ypwm;
`ifdef SERVO_SEQ_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  int tb_cyc;
  int xr, yr;
  int xw[$];
  int yw[$];

  servo_move_sequencer #(
    .FIFO_DEPTH(8), .FIFO_AW(3), .PWM_PERIOD(P), .PW_NEUTRAL(NEU),
    .PW_FULL_REVERSE(REV), .PW_FULL_FORWARD(FWD)
  ) dut (
    .PCLK(clk), .PRESERN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
`ifdef SERVO_SEQ_IRQ_EN
    .x_servo_pwm(xpwm), .y_servo_pwm(ypwm), .seq_done_irq(irq)
`else
    .x_servo_pwm(xpwm), .y_servo_pwm(ypwm)
`endif
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT period counter modulo P.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  // Pulse-width monitor: records each completed high pulse length in cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      xr <= 0;
      yr <= 0;
    end else begin
      if (xpwm) xr <= xr + 1;
      else if (xr > 0) begin xw.push_back(xr); xr <= 0; end
      if (ypwm) yr <= yr + 1;
      else if (yr > 0) begin yw.push_back(yr); yr <= 0; end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1);
  end

  task automatic wait_periods(input int n);
    repeat (n * P) @(negedge clk);
  endtask

  task automatic wait_cnt(input int t);
    int k = 0;
    @(negedge clk);
    while ((tb_cyc % P) != t && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    if ((tb_cyc % P) != t) begin
      total++; bad++;
      $display("FAIL wait_cnt got=%0d want=%0d", tb_cyc % P, t);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (xpwm !== 1'b0) begin bad++; $display("FAIL rst_xpwm got=%b want=0", xpwm); end
    total++; if (ypwm !== 1'b0) begin bad++; $display("FAIL rst_ypwm got=%b want=0", ypwm); end
    xw.delete(); yw.delete();
    rst_n = 1'b1;
    wait_periods(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= xw.size() || xw[i] !== NEU || i >= yw.size() || yw[i] !== NEU) begin
        bad++;
        $display("FAIL t1_width[%0d] got x=%0d y=%0d want=%0d", i,
                 (i < xw.size()) ? xw[i] : -1, (i < yw.size()) ? yw[i] : -1, NEU);
      end
    end
    apb_read(32'h208, v);
    total++; if (v !== 32'h004) begin bad++; $display("FAIL t1_status got=%h want=004", v); end
    apb_read(32'h20C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t1_xpos got=%h want=0", v); end
    apb_read(32'h210, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t1_ypos got=%h want=0", v); end
    total++;
    if (pready !== 1'b1 || pslverr !== 1'b0) begin
      bad++; $display("FAIL t1_tieoffs got=%b%b want=10", pready, pslverr);
    end
  endtask

  task automatic test_fwd_move;
    logic [31:0] v;
    int xe[5] = '{FWD, FWD, FWD, NEU, NEU};
    wait_cnt(40);
    apb_write(32'h200, 32'h0001_0003);
    apb_write(32'h204, 32'h1);
    wait_cnt(60);
    xw.delete(); yw.delete();
    wait_periods(3);
    apb_read(32'h208, v);
    total++; if (v !== 32'h006) begin bad++; $display("FAIL t2_busy got=%h want=006", v); end
    wait_cnt(60);
    apb_read(32'h208, v);
    total++;
    if (v !== (32'h004 | IRQB)) begin
      bad++; $display("FAIL t2_idle got=%h want=%h", v, 32'h004 | IRQB);
    end
    apb_read(32'h20C, v);
    total++; if (v !== 32'd3) begin bad++; $display("FAIL t2_xpos got=%h want=3", v); end
    wait_cnt(60);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= xw.size() || xw[i] !== xe[i] || i >= yw.size() || yw[i] !== NEU) begin
        bad++;
        $display("FAIL t2_width[%0d] got x=%0d y=%0d want x=%0d y=%0d", i,
                 (i < xw.size()) ? xw[i] : -1, (i < yw.size()) ? yw[i] : -1, xe[i], NEU);
      end
    end
`ifdef SERVO_SEQ_IRQ_EN
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL t2_irq got=%b want=1", irq); end
`endif
    apb_write(32'h204, 32'h8);
  endtask

  task automatic test_fifo;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) apb_write(32'h200, 32'h0005_0001);
    apb_read(32'h208, v);
    total++; if (v !== 32'h088) begin bad++; $display("FAIL t3_full got=%h want=088", v); end
    apb_write(32'h200, 32'h0005_0001);
    apb_read(32'h208, v);
    total++; if (v !== 32'h089) begin bad++; $display("FAIL t3_overflow got=%h want=089", v); end
    apb_write(32'h204, 32'h4);
    apb_read(32'h208, v);
    total++; if (v !== 32'h088) begin bad++; $display("FAIL t3_errclr got=%h want=088", v); end
    apb_write(32'h200, 32'h0005_0000);
    apb_read(32'h208, v);
    total++; if (v !== 32'h089) begin bad++; $display("FAIL t3_zero got=%h want=089", v); end
    apb_write(32'h204, 32'h2);
    apb_read(32'h208, v);
    total++; if (v !== 32'h005) begin bad++; $display("FAIL t3_flush got=%h want=005", v); end
    apb_write(32'h204, 32'h4);
    apb_read(32'h208, v);
    total++; if (v !== 32'h004) begin bad++; $display("FAIL t3_clean got=%h want=004", v); end
  endtask

  task automatic test_midperiod;
    logic [31:0] v;
    int xe[4] = '{FWD, FWD, NEU, NEU};
    apb_write(32'h204, 32'h1);
    wait_cnt(100);
    xw.delete(); yw.delete();
    apb_write(32'h200, 32'h0001_0002);
    wait_cnt(100);
    wait_periods(3);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= xw.size() || xw[i] !== xe[i] || i >= yw.size() || yw[i] !== NEU) begin
        bad++;
        $display("FAIL t4_width[%0d] got x=%0d y=%0d want x=%0d y=%0d", i,
                 (i < xw.size()) ? xw[i] : -1, (i < yw.size()) ? yw[i] : -1, xe[i], NEU);
      end
    end
    apb_read(32'h20C, v);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL t4_xpos got=%h want=5", v); end
    apb_write(32'h204, 32'h9);
  endtask

  task automatic test_flush;
    logic [31:0] v;
    int ye[6] = '{REV, REV, REV, REV, REV, NEU};
    wait_cnt(50);
    apb_write(32'h200, 32'h0006_000A);
    wait_cnt(60);
    xw.delete(); yw.delete();
    wait_cnt(100);
    wait_periods(5);
    apb_read(32'h208, v);
    total++; if (v !== 32'h006) begin bad++; $display("FAIL t5_busy got=%h want=006", v); end
    apb_write(32'h204, 32'h3);
    wait_cnt(60);
    wait_periods(1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= yw.size() || yw[i] !== ye[i] || i >= xw.size() || xw[i] !== NEU) begin
        bad++;
        $display("FAIL t5_width[%0d] got x=%0d y=%0d want x=%0d y=%0d", i,
                 (i < xw.size()) ? xw[i] : -1, (i < yw.size()) ? yw[i] : -1, NEU, ye[i]);
      end
    end
    apb_read(32'h210, v);
    total++; if (v !== 32'hFFFF_FFFB) begin bad++; $display("FAIL t5_ypos got=%h want=fffffffb", v); end
    apb_read(32'h208, v);
    total++;
    if (v !== (32'h004 | IRQB)) begin
      bad++; $display("FAIL t5_status got=%h want=%h", v, 32'h004 | IRQB);
    end
`ifdef SERVO_SEQ_IRQ_EN
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL t5_irq got=%b want=1", irq); end
`endif
    apb_write(32'h204, 32'h8);
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    apb_write(32'h200, 32'h0001_0005);
    apb_write(32'h200, 32'h0001_0005);
    apb_write(32'h204, 32'h1);
    wait_cnt(100);
    wait_periods(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (xpwm !== 1'b0 || ypwm !== 1'b0) begin
      bad++; $display("FAIL t6_pwm_in_reset got=%b%b want=00", xpwm, ypwm);
    end
    xw.delete(); yw.delete();
    rst_n = 1'b1;
    apb_read(32'h208, v);
    total++; if (v !== 32'h004) begin bad++; $display("FAIL t6_status got=%h want=004", v); end
    apb_read(32'h20C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t6_xpos got=%h want=0", v); end
    apb_read(32'h210, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL t6_ypos got=%h want=0", v); end
    wait_cnt(60);
    wait_periods(2);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= xw.size() || xw[i] !== NEU || i >= yw.size() || yw[i] !== NEU) begin
        bad++;
        $display("FAIL t6_width[%0d] got x=%0d y=%0d want=%0d", i,
                 (i < xw.size()) ? xw[i] : -1, (i < yw.size()) ? yw[i] : -1, NEU);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_move();
    test_fifo();
    test_midperiod();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
